// File: rtl/fifo_sync_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_sync_ctrl
//
// Single-clock pointer/flag controller for a dual-port FIFO memory array. The
// memory has a registered read port (r_data <= memory[r_addre] on every edge)
// and writes memory[w_addre] on an edge where its write enable is high.
//
// The controller:
//   - generates write and read addresses that wrap at depth, which does not
//     have to be a power of two
//   - tracks occupancy and derives the full/empty and almost-full/almost-empty
//     flags from it
//   - raises rd_valid in the cycle where r_data holds the popped word
//   - keeps sticky overflow/underflow error bits for the register file
//
// Ports:
//   clk          : single clock for all state
//   rst          : asynchronous, active-high reset
//   w_inc        : push request (write data is presented to the memory in the
//                  same cycle)
//   r_inc        : pop request
//   clr_err      : synchronous clear of the overflow/underflow sticky bits
//   w_addre      : write address to the memory
//   r_addre      : read address to the memory
//   mem_w_en     : accepted push, drives the memory write enable (combinational)
//   full         : count == depth
//   empty        : count == 0
//   almost_full  : count >= almost_full_thr
//   almost_empty : count <= almost_empty_thr
//   count        : current occupancy, 0..depth
//   rd_valid     : memory r_data holds the popped word this cycle
//   overflow     : sticky, push requested while full
//   underflow    : sticky, pop requested while empty
// -----------------------------------------------------------------------------
module fifo_sync_ctrl #(
  parameter int depth            = 10,
  parameter int address_width    = 4,
  parameter int almost_full_thr  = 8,
  parameter int almost_empty_thr = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_inc,
  input  logic                     r_inc,
  input  logic                     clr_err,
  output logic [address_width-1:0] w_addre,
  output logic [address_width-1:0] r_addre,
  output logic                     mem_w_en,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [address_width:0]   count,
  output logic                     rd_valid,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int count_width = address_width + 1;

  localparam logic [address_width-1:0] addr_zero  = {address_width{1'b0}};
  localparam logic [address_width-1:0] addr_one   = address_width'(1);
  localparam logic [address_width-1:0] addr_last  = address_width'(depth - 1);
  localparam logic [count_width-1:0]   count_zero = {count_width{1'b0}};
  localparam logic [count_width-1:0]   count_one  = count_width'(1);
  localparam logic [count_width-1:0]   count_full = count_width'(depth);
  localparam logic [count_width-1:0]   af_level   = count_width'(almost_full_thr);
  localparam logic [count_width-1:0]   ae_level   = count_width'(almost_empty_thr);

  // Address after an accepted transfer: wraps from depth-1 back to zero, so
  // the unused codes depth..2^address_width-1 are never produced.
  function automatic logic [address_width-1:0] ptr_next(
    input logic [address_width-1:0] ptr
  );
    logic [address_width-1:0] nxt;
    if (ptr == addr_last) begin
      nxt = addr_zero;
    end else begin
      nxt = ptr + addr_one;
    end
    return nxt;
  endfunction

  // Registered state
  logic [address_width-1:0] w_addr_r;
  logic [address_width-1:0] r_addr_r;
  logic [count_width-1:0]   count_r;
  logic                     full_r;
  logic                     empty_r;
  logic                     almost_full_r;
  logic                     almost_empty_r;
  logic                     rd_valid_r;
  logic                     overflow_r;
  logic                     underflow_r;

  // Next-state values
  logic                     push_ok_s;
  logic                     pop_ok_s;
  logic [address_width-1:0] w_addr_nxt_s;
  logic [address_width-1:0] r_addr_nxt_s;
  logic [count_width-1:0]   count_nxt_s;
  logic                     full_nxt_s;
  logic                     empty_nxt_s;
  logic                     almost_full_nxt_s;
  logic                     almost_empty_nxt_s;
  logic                     overflow_nxt_s;
  logic                     underflow_nxt_s;

  // Acceptance uses the registered flags only, so requests never see a flag
  // derived from themselves.
  always_comb begin
    push_ok_s = w_inc & ~full_r;
    pop_ok_s  = r_inc & ~empty_r;
  end

  // Pointer advance on accepted transfers.
  always_comb begin
    w_addr_nxt_s = w_addr_r;
    r_addr_nxt_s = r_addr_r;
    if (push_ok_s) begin
      w_addr_nxt_s = ptr_next(w_addr_r);
    end else begin
      w_addr_nxt_s = w_addr_r;
    end
    if (pop_ok_s) begin
      r_addr_nxt_s = ptr_next(r_addr_r);
    end else begin
      r_addr_nxt_s = r_addr_r;
    end
  end

  // Occupancy update; a simultaneous accepted push and pop cancel out.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + count_one;
      2'b01:   count_nxt_s = count_r - count_one;
      default: count_nxt_s = count_r;
    endcase
  end

  // Flags come from the next-state count so they line up with the new count.
  always_comb begin
    full_nxt_s         = (count_nxt_s == count_full);
    empty_nxt_s        = (count_nxt_s == count_zero);
    almost_full_nxt_s  = (count_nxt_s >= af_level);
    almost_empty_nxt_s = (count_nxt_s <= ae_level);
  end

  // Sticky errors: a set event in the same cycle as clr_err wins.
  always_comb begin
    overflow_nxt_s  = overflow_r;
    underflow_nxt_s = underflow_r;
    if (w_inc & full_r) begin
      overflow_nxt_s = 1'b1;
    end else if (clr_err) begin
      overflow_nxt_s = 1'b0;
    end else begin
      overflow_nxt_s = overflow_r;
    end
    if (r_inc & empty_r) begin
      underflow_nxt_s = 1'b1;
    end else if (clr_err) begin
      underflow_nxt_s = 1'b0;
    end else begin
      underflow_nxt_s = underflow_r;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_addr_r <= addr_zero;
      r_addr_r <= addr_zero;
      count_r  <= count_zero;
    end else begin
      w_addr_r <= w_addr_nxt_s;
      r_addr_r <= r_addr_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

  // Status flag registers; reset reflects an empty FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
    end else begin
      full_r         <= full_nxt_s;
      empty_r        <= empty_nxt_s;
      almost_full_r  <= almost_full_nxt_s;
      almost_empty_r <= almost_empty_nxt_s;
    end
  end

  // Read-valid strobe: the memory captures memory[old r_addre] on the same
  // edge that advances r_addre, so the popped word is on r_data next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= pop_ok_s;
    end
  end

  // Sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_nxt_s;
      underflow_r <= underflow_nxt_s;
    end
  end

  // Output mapping; mem_w_en must act on the current edge, so it stays
  // combinational from w_inc and the registered full flag.
  always_comb begin
    mem_w_en     = push_ok_s;
    w_addre      = w_addr_r;
    r_addre      = r_addr_r;
    count        = count_r;
    full         = full_r;
    empty        = empty_r;
    almost_full  = almost_full_r;
    almost_empty = almost_empty_r;
    rd_valid     = rd_valid_r;
    overflow     = overflow_r;
    underflow    = underflow_r;
  end

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_ctrl
//
// Bench for fifo_sync_ctrl with a registered-read memory attached. A queue
// model predicts occupancy, addresses, flags, errors and the popped data.
// Outputs are compared against the model on every falling edge. Directed
// scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_fifo_sync_ctrl;

  localparam int DEPTH = 10;
  localparam int AW    = 4;

  logic          clk;
  logic          rst;
  logic          w_inc;
  logic          r_inc;
  logic          clr_err;
  logic [AW-1:0] w_addre;
  logic [AW-1:0] r_addre;
  logic          mem_w_en;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          rd_valid;
  logic          overflow;
  logic          underflow;

  logic [7:0] w_data;
  logic [7:0] r_data;
  logic [7:0] mem [0:15];

  fifo_sync_ctrl #(
    .depth(DEPTH), .address_width(AW), .almost_full_thr(8), .almost_empty_thr(2)
  ) dut (
    .clk(clk), .rst(rst), .w_inc(w_inc), .r_inc(r_inc), .clr_err(clr_err),
    .w_addre(w_addre), .r_addre(r_addre), .mem_w_en(mem_w_en),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .rd_valid(rd_valid),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read memory array driven by the controller
  always @(posedge clk) begin
    if (mem_w_en) mem[w_addre] <= w_data;
    r_data <= mem[r_addre];
  end

  // ---------------- behavioural model ----------------
  logic [7:0] q[$];
  int         m_wp, m_rp;
  bit         m_ovf, m_unf, m_rdv;
  logic [7:0] m_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_wp = 0; m_rp = 0;
    m_ovf = 0; m_unf = 0; m_rdv = 0; m_rdata = 8'h00;
  endtask

  // Predict the state after the coming rising edge.
  task automatic model_step(input bit w, input bit r, input bit c, input logic [7:0] d);
    bit is_full, is_empty, push, pop;
    is_full  = (q.size() == DEPTH);
    is_empty = (q.size() == 0);
    push = w && !is_full;
    pop  = r && !is_empty;
    m_rdv = pop;
    if (pop) begin
      m_rdata = q.pop_front();
      m_rp = (m_rp + 1) % DEPTH;
    end
    if (push) begin
      q.push_back(d);
      m_wp = (m_wp + 1) % DEPTH;
    end
    if (w && is_full) m_ovf = 1;
    else if (c) m_ovf = 0;
    if (r && is_empty) m_unf = 1;
    else if (c) m_unf = 0;
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    chk("count",        int'(count),        n);
    chk("full",         int'(full),         int'(n == DEPTH));
    chk("empty",        int'(empty),        int'(n == 0));
    chk("almost_full",  int'(almost_full),  int'(n >= 8));
    chk("almost_empty", int'(almost_empty), int'(n <= 2));
    chk("w_addre",      int'(w_addre),      m_wp);
    chk("r_addre",      int'(r_addre),      m_rp);
    chk("rd_valid",     int'(rd_valid),     int'(m_rdv));
    chk("overflow",     int'(overflow),     int'(m_ovf));
    chk("underflow",    int'(underflow),    int'(m_unf));
    if (m_rdv) chk("r_data", int'(r_data), int'(m_rdata));
  endtask

  // One clock cycle: check the current state, apply inputs, check the
  // write enable, then advance the model to match the next edge.
  task automatic cyc(input bit w, input bit r, input bit c, input logic [7:0] d);
    @(negedge clk);
    compare_all();
    w_inc = w; r_inc = r; clr_err = c; w_data = d;
    #1;
    chk("mem_w_en", int'(mem_w_en), int'(w && (q.size() != DEPTH)));
    model_step(w, r, c, d);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; w_inc = 0; r_inc = 0; clr_err = 0; w_data = 8'h00;
    model_reset();
    #12;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_almost_empty", int'(almost_empty), 1);
    chk("rst_full", int'(full), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: ten pushes, almost_full from count 8
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, 0, 8'(8'h11 + i));
      after_edge();
      chk("s1_count", int'(count), i + 1);
      chk("s1_almost_full", int'(almost_full), int'(i + 1 >= 8));
    end
    chk("s1_full", int'(full), 1);
    chk("s1_w_addre_wrap", int'(w_addre), 0);
    chk("s1_empty", int'(empty), 0);

    // 2: push while full
    cyc(1, 0, 0, 8'h55);
    chk("s2_mem_w_en", int'(mem_w_en), 0);
    after_edge();
    chk("s2_overflow", int'(overflow), 1);
    chk("s2_count", int'(count), 10);
    chk("s2_mem0", int'(mem[0]), 8'h11);
    cyc(0, 0, 1, 8'h00);
    after_edge();
    chk("s2_clr", int'(overflow), 0);

    // 3: drain, data returns in order, then one pop too many
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, 0, 8'h00);
      after_edge();
      chk("s3_rd_valid", int'(rd_valid), 1);
      chk("s3_rdata", int'(r_data), 8'h11 + i);
    end
    chk("s3_empty", int'(empty), 1);
    chk("s3_r_addre_wrap", int'(r_addre), 0);
    cyc(0, 1, 0, 8'h00);
    after_edge();
    chk("s3_underflow", int'(underflow), 1);
    chk("s3_no_rd_valid", int'(rd_valid), 0);

    // 4: simultaneous push/pop at full and at empty
    cyc(0, 0, 1, 8'h00);
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 8'(8'h30 + i));
    cyc(1, 1, 0, 8'h99);
    after_edge();
    chk("s4_full_count", int'(count), 9);
    chk("s4_full_ovf", int'(overflow), 1);
    chk("s4_full_rdata", int'(r_data), 8'h30);
    for (int i = 0; i < 9; i++) cyc(0, 1, 1, 8'h00);
    cyc(1, 1, 0, 8'h77);
    after_edge();
    chk("s4_empty_count", int'(count), 1);
    chk("s4_empty_unf", int'(underflow), 1);
    chk("s4_empty_rdv", int'(rd_valid), 0);

    // 5: count 5 at r_addre 7, then 20 cycles of push+pop
    cyc(0, 0, 1, 8'h00);
    while (m_rp != 7) begin
      if (q.size() == 0) cyc(1, 0, 0, 8'($urandom));
      else cyc(0, 1, 0, 8'h00);
    end
    while (q.size() != 5) cyc(1, 0, 0, 8'($urandom));
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 8'($urandom));
    after_edge();
    chk("s5_count", int'(count), 5);
    chk("s5_r_addre", int'(r_addre), 7);

    // 6: asynchronous reset at count 6
    cyc(1, 0, 0, 8'h42);
    @(negedge clk);
    compare_all();
    w_inc = 0; r_inc = 0; clr_err = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("s6_count", int'(count), 0);
    chk("s6_w_addre", int'(w_addre), 0);
    chk("s6_r_addre", int'(r_addre), 0);
    chk("s6_empty", int'(empty), 1);
    chk("s6_almost_empty", int'(almost_empty), 1);
    chk("s6_flags", int'({full, almost_full, rd_valid, overflow, underflow}), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 0, 0, 8'hA5);
    cyc(0, 1, 0, 8'h00);
    after_edge();
    chk("s6_rd_valid", int'(rd_valid), 1);
    chk("s6_rdata", int'(r_data), 8'hA5);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      bit w, r, c;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 99) < 5);
      cyc(w, r, c, 8'($urandom));
    end
    @(negedge clk);
    compare_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync_ctrl.md
Name: fifo_sync_ctrl

Overview:
Single-clock pointer/flag controller that sequences the team's dual-port FIFO memory array (registered read, write gated by not-full and write-increment).
- Generates write/read addresses with wrap at a non-power-of-two depth.
- Maintains occupancy count, full/empty and almost-full/almost-empty flags.
- Raises a read-data-valid strobe aligned to the memory's one-cycle read latency.
- Records sticky overflow/underflow errors for the register file.

Parameters:
depth, 10, number of memory entries; addresses run 0..depth-1
address_width, 4, width of w_addre/r_addre; must satisfy 2^address_width >= depth
almost_full_thr, 8, almost_full asserted when count >= this value
almost_empty_thr, 2, almost_empty asserted when count <= this value

Ports:
clk  in  1  single clock for all state
rst  in  1  asynchronous, active-high reset
w_inc  in  1  push request (data presented to memory in the same cycle)
r_inc  in  1  pop request
clr_err  in  1  synchronous clear of overflow/underflow sticky flags
w_addre  out  address_width  write address to memory
r_addre  out  address_width  read address to memory
mem_w_en  out  1  accepted push; drives the memory's w_inc (memory is_full tied to full)
full  out  1  count == depth
empty  out  1  count == 0
almost_full  out  1  count >= almost_full_thr
almost_empty  out  1  count <= almost_empty_thr
count  out  address_width+1  current occupancy, 0..depth
rd_valid  out  1  memory r_data holds the popped word this cycle
overflow  out  1  sticky: push requested while full
underflow  out  1  sticky: pop requested while empty

Behaviour:
- Reset (async assert, any cycle including mid-transfer) forces these values:
  - w_addre=0, r_addre=0, count=0
  - empty=1, almost_empty=1
  - full=0, almost_full=0, rd_valid=0, overflow=0, underflow=0
  - Memory contents are not cleared.
- Push acceptance and write enable:
  - push_ok = w_inc & !full.
  - pop_ok = r_inc & !empty.
  - full/empty are the registered flags from the previous edge.
  - mem_w_en = push_ok (combinational); the memory writes at w_addre on that edge.
- Pointer wrap: on push_ok, w_addre <= (w_addre == depth-1) ? 0 : w_addre+1. r_addre follows the same rule on pop_ok. Values depth..2^address_width-1 are never produced.
- Count update on each edge:
  - push_ok only: +1
  - pop_ok only: -1
  - both or neither: unchanged
- Flags are registered and recomputed from the next-state count, so they are valid in the same cycle as the new count. No combinational path exists from w_inc/r_inc to any flag.
- Read timing:
  - r_addre is held stable before the pop; the memory registers memory[r_addre] every edge.
  - On pop_ok, rd_valid <= 1 for exactly one cycle. In that cycle r_data holds the entry at the pre-increment r_addre.
  - Because the memory re-reads every edge, r_addre advances on the same edge that r_data captures the old location.
  - Consumers sample r_data only while rd_valid=1.
- Simultaneous push and pop:
  - When full: pop accepted, push rejected, overflow set, count becomes depth-1.
  - When empty: push accepted, pop rejected, underflow set, count becomes 1, rd_valid stays 0.
  - Otherwise: both accepted, count unchanged, both pointers advance.
- Errors:
  - overflow <= 1 on w_inc & full.
  - underflow <= 1 on r_inc & empty.
  - clr_err clears both. If a set event and clr_err occur in the same cycle, the set wins.
- No state machine beyond the pointer/count registers. The controller has no internal stall and a pop issued on cycle N yields rd_valid on cycle N+1.

Test Plan:
1. Reset, then 10 consecutive pushes of 0x11..0x1A.
   -> w_addre steps 0..9 then wraps to 0; count=10; full=1; almost_full=1 from count=8; empty=0.
2. From full, push 0x55 with no pop.
   -> mem_w_en=0; memory[0] retains 0x11; overflow=1 next cycle; count stays 10.
   -> Pulse clr_err -> overflow=0.
3. From full, 10 pops.
   -> rd_valid one cycle after each pop; r_data sequence 0x11..0x1A; r_addre wraps 9->0; empty=1 after the last pop.
   -> An 11th pop sets underflow=1 with no rd_valid.
4. At count=10, push and pop together.
   -> Pop accepted, push rejected, count=9, overflow=1.
   -> At count=0, push and pop together: count=1, underflow=1, rd_valid=0.
5. At count=5 with r_addre=7, continuous simultaneous push/pop for 20 cycles.
   -> count stays 5; both pointers wrap twice; read data order matches write order.
6. Assert rst asynchronously (between clock edges) at count=6.
   -> All outputs reach reset values immediately.
   -> After release, a push to address 0 and a pop return the new data with rd_valid=1.
